// File: rtl/radar_sweep_ctrl.sv
// radar_sweep_ctrl
//   Steps the radar servo through MIN_US..MAX_US in STEP_US increments, lets
//   it settle SETTLE_PERIODS PWM periods at each position, requests one range
//   measurement and reports the distance tagged with the position index.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   start              one-cycle sweep request (ignored while busy)
//   busy, done         sweep in progress / one-cycle end-of-sweep pulse
//   pwm_enable         enable for the pwm block
//   pwm_dutty          servo pulse width in us
//   pwm_period         constant PERIOD_US
//   meas_req           level request to the ranger (high in MEASURE)
//   meas_done          one-cycle ranger answer, meas_dist valid alongside
//   result_valid       one-cycle report strobe per position
//   result_idx         position index, 0 = MIN_US
//   result_dist        captured distance, 16'hFFFF on timeout
//   result_err         measurement timed out
//
// Build option
//   RADAR_SWEEP_BIDIR_EN  sweep up to N-1 then back down to 0 (2N-1 reports).
//                         Undefined: one upward pass, N reports.
module radar_sweep_ctrl #(
  parameter int TICK_DIV       = 100,
  parameter int PERIOD_US      = 20000,
  parameter int MIN_US         = 1000,
  parameter int MAX_US         = 2000,
  parameter int STEP_US        = 500,
  parameter int SETTLE_PERIODS = 25,
  parameter int TIMEOUT_US     = 30000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pwm_enable,
  output logic [15:0] pwm_dutty,
  output logic [15:0] pwm_period,
  output logic        meas_req,
  input  logic        meas_done,
  input  logic [15:0] meas_dist,
  output logic        result_valid,
  output logic [3:0]  result_idx,
  output logic [15:0] result_dist,
  output logic        result_err
);

  localparam int         NPOS     = (MAX_US - MIN_US) / STEP_US + 1;
  localparam int         DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] LAST_IDX = 4'(NPOS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_SETTLE, S_MEASURE, S_REPORT, S_NEXT
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [15:0]      tick_cnt, per_cnt, to_cnt;
  logic [3:0]       idx, idx_nxt;
  logic             last_pos;
  logic             period_end, settle_end, timeout;

  // Free-running us strobe; never cleared by the FSM, so the first tick of a
  // wait window can land anywhere within one TICK_DIV phase.
  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + 1'b1;
  end

  assign period_end = tick && (tick_cnt == 16'(PERIOD_US - 1));
  assign settle_end = period_end && (per_cnt == 16'(SETTLE_PERIODS - 1));
  assign timeout    = tick && (to_cnt == 16'(TIMEOUT_US - 1));

  // Position sequencing: where to go after the current report.
`ifdef RADAR_SWEEP_BIDIR_EN
  logic dir_down, dir_nxt;

  always_comb begin
    last_pos = 1'b0;
    idx_nxt  = idx;
    dir_nxt  = dir_down;
    if (!dir_down) begin
      if (idx != LAST_IDX) idx_nxt = idx + 4'd1;
      else if (idx == 4'd0) last_pos = 1'b1;     // single-position sweep
      else begin
        dir_nxt = 1'b1;                          // turn around at the top
        idx_nxt = idx - 4'd1;
      end
    end else begin
      if (idx != 4'd0) idx_nxt = idx - 4'd1;
      else             last_pos = 1'b1;
    end
  end
`else
  always_comb begin
    last_pos = (idx == LAST_IDX);
    idx_nxt  = idx + 4'd1;
  end
`endif

  always_comb begin
    state_nxt    = state;
    busy         = (state != S_IDLE);
    meas_req     = (state == S_MEASURE);
    result_valid = (state == S_REPORT);
    done         = (state == S_NEXT) && last_pos;
    case (state)
      S_IDLE:    if (start) state_nxt = S_MOVE;
      S_MOVE:    state_nxt = S_SETTLE;
      S_SETTLE:  if (settle_end) state_nxt = S_MEASURE;
      S_MEASURE: if (meas_done || timeout) state_nxt = S_REPORT;
      S_REPORT:  state_nxt = S_NEXT;
      S_NEXT:    state_nxt = last_pos ? S_IDLE : S_MOVE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign result_idx = idx;
  assign pwm_period = 16'(PERIOD_US);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= 4'd0;
      pwm_dutty   <= 16'(MIN_US);
      pwm_enable  <= 1'b0;
      tick_cnt    <= '0;
      per_cnt     <= '0;
      to_cnt      <= '0;
      result_dist <= '0;
      result_err  <= 1'b0;
`ifdef RADAR_SWEEP_BIDIR_EN
      dir_down    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          idx       <= 4'd0;
          pwm_dutty <= 16'(MIN_US);
`ifdef RADAR_SWEEP_BIDIR_EN
          dir_down  <= 1'b0;
`endif
        end
        S_MOVE: begin
          pwm_enable <= 1'b1;
          tick_cnt   <= '0;
          per_cnt    <= '0;
          to_cnt     <= '0;
        end
        S_SETTLE: begin
          if (period_end) begin
            tick_cnt <= '0;
            per_cnt  <= per_cnt + 16'd1;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 16'd1;
          end
        end
        S_MEASURE: begin
          if (tick) to_cnt <= to_cnt + 16'd1;
          // An answer in the timeout cycle still counts as a valid answer.
          if (meas_done) begin
            result_dist <= meas_dist;
            result_err  <= 1'b0;
          end else if (timeout) begin
            result_dist <= 16'hFFFF;
            result_err  <= 1'b1;
          end
        end
        S_NEXT: begin
          if (last_pos) begin
            pwm_enable <= 1'b0;
          end else begin
            idx       <= idx_nxt;
            pwm_dutty <= 16'(MIN_US) + 16'(idx_nxt) * 16'(STEP_US);
`ifdef RADAR_SWEEP_BIDIR_EN
            dir_down  <= dir_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radar_sweep_ctrl.sv
// Bench for radar_sweep_ctrl with small timing overrides (N = 3 positions).
// A ranger model answers each request after a chosen delay; the expected
// reports come from the position list and the timeout window in cycles.
module tb_radar_sweep_ctrl;

  localparam int TD     = 2;
  localparam int PER    = 20;
  localparam int SETP   = 2;
  localparam int TMO    = 50;
  localparam int MINU   = 1000;
  localparam int MAXU   = 2000;
  localparam int STEPU  = 500;
  localparam int N      = (MAXU - MINU) / STEPU + 1;
  localparam int TMO_CYC = TMO * TD;          // timeout window in clk cycles
  localparam int S_NOM   = SETP * PER * TD;   // settle window in clk cycles
  localparam int NEVER   = 1000;
`ifdef RADAR_SWEEP_BIDIR_EN
  localparam int NR = 2 * N - 1;
`else
  localparam int NR = N;
`endif

  logic        clk = 1'b0;
  logic        reset, start, meas_done;
  logic [15:0] meas_dist;
  logic        busy, done, pwm_enable, meas_req, result_valid, result_err;
  logic [15:0] pwm_dutty, pwm_period, result_dist;
  logic [3:0]  result_idx;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          dly_q[32];
  logic [15:0] dist_q[32];

  always #5 clk = ~clk;

  radar_sweep_ctrl #(
    .TICK_DIV(TD), .PERIOD_US(PER), .MIN_US(MINU), .MAX_US(MAXU),
    .STEP_US(STEPU), .SETTLE_PERIODS(SETP), .TIMEOUT_US(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .pwm_enable(pwm_enable), .pwm_dutty(pwm_dutty), .pwm_period(pwm_period),
    .meas_req(meas_req), .meas_done(meas_done), .meas_dist(meas_dist),
    .result_valid(result_valid), .result_idx(result_idx),
    .result_dist(result_dist), .result_err(result_err)
  );

  // Position visited at report number p.
  function automatic int exp_idx(input int p);
    return (p < N) ? p : 2 * N - 2 - p;
  endfunction

  // Runs one sweep from IDLE, playing the ranger from dly_q/dist_q.
  // abort_pos >= 0 resets the DUT on the first MEASURE cycle of that report.
  task automatic drive_sweep(input bit stray, input int abort_pos);
    int pos, cyc, mv, rise, last_r, lat_w, sett;
    logic [15:0] dist_w;
    logic        err_w;
    bit fin, saw_done;
    pos = 0; cyc = 0; mv = 0; rise = -1; last_r = -100; fin = 0; saw_done = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL busy_after_start: got %0b want 1", busy);
    end
    while (!fin) begin
      meas_done = 1'b0;
      start     = 1'b0;
      if (cyc == 1) begin
        n_cmp++;
        if (pwm_enable !== 1'b1) begin
          n_bad++; $display("FAIL enable_latency: got %0b want 1", pwm_enable);
        end
      end
      if (meas_req && rise < 0) begin
        rise = cyc;
        sett = cyc - mv - 1;
        n_cmp++;
        if (sett < S_NOM - TD + 1 || sett > S_NOM) begin
          n_bad++; $display("FAIL settle_len pos=%0d: got %0d want %0d..%0d", pos, sett, S_NOM - TD + 1, S_NOM);
        end
        n_cmp++;
        if (pwm_dutty !== 16'(MINU + exp_idx(pos) * STEPU)) begin
          n_bad++; $display("FAIL dutty pos=%0d: got %0d want %0d", pos, pwm_dutty, MINU + exp_idx(pos) * STEPU);
        end
        if (pos == abort_pos) begin
          reset = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0;
          n_cmp++;
          if ({pwm_enable, meas_req, busy, done} !== 4'b0000) begin
            n_bad++; $display("FAIL abort_outputs: got en/req/busy/done=%b want 0000", {pwm_enable, meas_req, busy, done});
          end
          for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
              n_bad++; $display("FAIL abort_idle: got done=%0b busy=%0b want 0 0", done, busy);
            end
          end
          return;
        end
      end
      if (rise >= 0 && (cyc - rise) == dly_q[pos]) begin
        meas_done = 1'b1;
        meas_dist = dist_q[pos];
      end
      if (stray && busy && !meas_req && (cyc - mv) == 20) begin
        start     = 1'b1;
        meas_done = 1'b1;
        meas_dist = 16'hDEAD;
      end
      if (result_valid) begin
        if (dly_q[pos] < TMO_CYC) begin
          dist_w = dist_q[pos]; err_w = 1'b0; lat_w = dly_q[pos] + 1;
        end else begin
          dist_w = 16'hFFFF; err_w = 1'b1; lat_w = TMO_CYC;
        end
        n_cmp++;
        if (pos >= NR || rise < 0) begin
          n_bad++; $display("FAIL extra_report: pos=%0d rise=%0d", pos, rise);
        end else if (result_idx !== 4'(exp_idx(pos)) || result_dist !== dist_w ||
                     result_err !== err_w || (cyc - rise) !== lat_w || meas_req !== 1'b0) begin
          n_bad++;
          $display("FAIL report pos=%0d: got idx=%0d dist=%0d err=%0b lat=%0d req=%0b want idx=%0d dist=%0d err=%0b lat=%0d req=0",
                   pos, result_idx, result_dist, result_err, cyc - rise, meas_req,
                   exp_idx(pos), dist_w, err_w, lat_w);
        end
        pos++; rise = -1; mv = cyc + 2; last_r = cyc;
      end
      if (done) begin
        n_cmp++;
        if (pos !== NR || cyc !== last_r + 1) begin
          n_bad++; $display("FAIL done_timing: got reports=%0d gap=%0d want %0d 1", pos, cyc - last_r, NR);
        end
        fin = 1; saw_done = 1;
      end
      if (cyc > 4000) begin
        n_cmp++; n_bad++;
        $display("FAIL sweep_timeout: got reports=%0d want %0d", pos, NR);
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    meas_done = 1'b0;
    start     = 1'b0;
    if (saw_done) begin
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0 || pwm_enable !== 1'b0 || pwm_dutty !== 16'(MINU + exp_idx(NR - 1) * STEPU)) begin
        n_bad++; $display("FAIL after_done: got busy=%0b en=%0b dutty=%0d want 0 0 %0d",
                          busy, pwm_enable, pwm_dutty, MINU + exp_idx(NR - 1) * STEPU);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int p = 0; p < 32; p++) begin
      dly_q[p]  = $urandom_range(hi, lo);
      dist_q[p] = 16'($urandom_range(16'hFFFE, 0));
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; meas_done = 1'b0; meas_dist = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, pwm_enable, meas_req, result_valid, result_err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000",
                        {busy, done, pwm_enable, meas_req, result_valid, result_err});
    end
    n_cmp++;
    if (pwm_dutty !== 16'(MINU) || pwm_period !== 16'(PER)) begin
      n_bad++; $display("FAIL reset_pwm: got dutty=%0d period=%0d want %0d %0d", pwm_dutty, pwm_period, MINU, PER);
    end
    n_cmp++;
    if (result_idx !== 4'd0 || result_dist !== 16'd0) begin
      n_bad++; $display("FAIL reset_result: got idx=%0d dist=%0d want 0 0", result_idx, result_dist);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_sweep;
    for (int p = 0; p < 32; p++) begin
      dly_q[p]  = 5;
      dist_q[p] = 16'(100 * (p + 1));
    end
    drive_sweep(1'b0, -1);
  endtask

  task automatic test_timeout_idx1;
    fill_random(0, 60);
    dly_q[1] = NEVER;
    drive_sweep(1'b0, -1);
  endtask

  task automatic test_stray_inputs;
    fill_random(0, 40);
    drive_sweep(1'b1, -1);
  endtask

  task automatic test_timeout_edge;
    fill_random(90, 98);
    dly_q[0] = TMO_CYC - 1;   // answer lands in the timeout cycle
    dly_q[1] = TMO_CYC;       // answer one cycle late: ignored
    dly_q[2] = 0;             // answer in the first request cycle
    drive_sweep(1'b0, -1);
  endtask

  task automatic test_reset_mid_measure;
    fill_random(0, 30);
    dly_q[1] = NEVER;
    drive_sweep(1'b0, 1);
    fill_random(0, 30);
    drive_sweep(1'b0, -1);
  endtask

  task automatic test_back_to_back;
    for (int s = 0; s < 4; s++) begin
      fill_random(0, 140);
      drive_sweep(s[0], -1);
    end
  endtask

  initial begin
    start = 1'b0; meas_done = 1'b0; meas_dist = '0; reset = 1'b1;
    test_reset;
    test_basic_sweep;
    test_timeout_idx1;
    test_stray_inputs;
    test_timeout_edge;
    test_reset_mid_measure;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
